ahb_lite_reg_slave: RTL

AHB-Lite responder that maps a small bank of 32-bit control/status registers into the MCU's AHB window, for fabric peripherals beside ahb_foc_controller (e.g. diagnostic counters, tuning registers).
- Accepts single and burst transfers from the MCU AHB master.
- Supports byte, halfword and word writes.
- Inserts programmable wait states.
- Returns the two-cycle AHB ERROR response for illegal accesses.

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_lite_reg_slave_if.sv | 29 ++
 rtl/ahb_byte_strobe.sv | 21 ++
 rtl/ahb_lite_reg_slave.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder data-phase state type.
// Used by the register slave and by any peripheral that needs the byte-lane decode.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_WAIT,
    DP_DONE,
    DP_ERR1,
    DP_ERR2
  } dp_state_e;

endpackage

// File: rtl/ahb_lite_reg_slave_if.sv
// AHB-Lite bus bundle between the MCU master and a responder.
// The master drives address/control/write data; the slave returns hrdata/hresp/hready.
interface ahb_lite_reg_slave_if;

  logic [1:0]  I_ahb_htrans;
  logic        I_ahb_hwrite;
  logic [31:0] I_ahb_haddr;
  logic [2:0]  I_ahb_hsize;
  logic [2:0]  I_ahb_hburst;
  logic [3:0]  I_ahb_hprot;
  logic        I_ahb_hmastlock;
  logic [31:0] I_ahb_hwdata;
  logic [31:0] O_ahb_hrdata;
  logic [1:0]  O_ahb_hresp;
  logic        O_ahb_hready;

  modport master (
    output I_ahb_htrans, I_ahb_hwrite, I_ahb_haddr, I_ahb_hsize, I_ahb_hburst,
    output I_ahb_hprot, I_ahb_hmastlock, I_ahb_hwdata,
    input  O_ahb_hrdata, O_ahb_hresp, O_ahb_hready
  );

  modport slave (
    input  I_ahb_htrans, I_ahb_hwrite, I_ahb_haddr, I_ahb_hsize, I_ahb_hburst,
    input  I_ahb_hprot, I_ahb_hmastlock, I_ahb_hwdata,
    output O_ahb_hrdata, O_ahb_hresp, O_ahb_hready
  );

endinterface

// File: rtl/ahb_byte_strobe.sv
// Combinational byte-lane strobe from hsize and haddr[1:0]; zero latency, no flow control.
// Illegal sizes produce an all-zero strobe so no lane can be written.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] I_hsize,
  input  logic [1:0] I_addr,
  output logic [3:0] O_strb
);

  always_comb begin
    O_strb = 4'b0000;
    case (I_hsize)
      HSIZE_BYTE: O_strb = 4'b0001 << I_addr;
      HSIZE_HALF: O_strb = I_addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: O_strb = 4'b1111;
      default:    O_strb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_lite_reg_slave.sv
// AHB-Lite register bank: NRW R/W words plus live read-only words; OKAY beats take 1+WAIT_STATES
// cycles, ERROR beats take 2; the slave stalls the master only by pulling hready low.
module ahb_lite_reg_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h6000_1000,
  parameter int          NREG        = 16,
  parameter int          NRW         = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic                      I_ahb_clk,
  input  logic                      I_rst,
  ahb_lite_reg_slave_if.slave       ahb,
  output logic [NRW*32-1:0]         O_reg_q,
  output logic [NRW-1:0]            O_wr_pulse,
  input  logic [(NREG-NRW)*32-1:0]  I_ro_data
);

  localparam int AW  = $clog2(NREG);
  localparam int NRO = NREG - NRW;

  dp_state_e        state_q, state_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [3:0]       strb_q, strb_d;
  logic             hwrite_q, hwrite_d;
  logic [31:0]      reg_q [NRW];
  logic [31:0]      reg_d [NRW];
  logic [NRW-1:0]   wr_pulse_q, wr_pulse_d;

  logic             hready;
  logic             accept;
  logic             addr_err;
  logic             commit;
  logic [AW-1:0]    addr_idx;
  logic [3:0]       addr_strb;
  logic [31:0]      rd_word;
  logic             unused_ok;

  assign unused_ok = ^{ahb.I_ahb_hburst, ahb.I_ahb_hprot, ahb.I_ahb_hmastlock};
  assign addr_idx  = ahb.I_ahb_haddr[AW+1:2];

  ahb_byte_strobe u_byte_strobe (
    .I_hsize (ahb.I_ahb_hsize),
    .I_addr  (ahb.I_ahb_haddr[1:0]),
    .O_strb  (addr_strb)
  );

  always_comb begin
    addr_err = 1'b0;
    if (ahb.I_ahb_haddr[31:AW+2] != BASE_ADDR[31:AW+2]) addr_err = 1'b1;
    if (ahb.I_ahb_hsize > HSIZE_WORD) addr_err = 1'b1;
    if (ahb.I_ahb_hsize == HSIZE_WORD && ahb.I_ahb_haddr[1:0] != 2'b00) addr_err = 1'b1;
    if (ahb.I_ahb_hsize == HSIZE_HALF && ahb.I_ahb_haddr[0]) addr_err = 1'b1;
    if (ahb.I_ahb_hwrite && int'(addr_idx) >= NRW) addr_err = 1'b1;
  end

  // Address phase is only sampled while the previous data phase is completing.
  assign hready = (state_q != DP_WAIT) && (state_q != DP_ERR1);
  assign accept = hready && (ahb.I_ahb_htrans == HTRANS_NONSEQ || ahb.I_ahb_htrans == HTRANS_SEQ);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    strb_d     = strb_q;
    hwrite_d   = hwrite_q;
    case (state_q)
      DP_WAIT: begin
        if (wait_cnt_q <= 2'd1) state_d = DP_DONE;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      DP_ERR1: state_d = DP_ERR2;
      default: begin
        state_d = DP_IDLE;
        if (accept) begin
          idx_d    = addr_idx;
          strb_d   = addr_strb;
          hwrite_d = ahb.I_ahb_hwrite;
          if (addr_err) begin
            state_d = DP_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = DP_DONE;
          end else begin
            state_d    = DP_WAIT;
            wait_cnt_d = 2'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  // DP_DONE always ends on the next edge with hready=1/OKAY, so that edge commits the write.
  assign commit = (state_q == DP_DONE) && hwrite_q;

  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NRW; i++) begin
      reg_d[i] = reg_q[i];
      if (commit && idx_q == AW'(i)) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) reg_d[i][8*b +: 8] = ahb.I_ahb_hwdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NRW; i++) begin
      if (idx_q == AW'(i)) rd_word = reg_q[i];
    end
    for (int j = 0; j < NRO; j++) begin
      if (idx_q == AW'(NRW + j)) rd_word = I_ro_data[32*j +: 32];
    end
  end

  always_ff @(posedge I_ahb_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= DP_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      strb_q     <= '0;
      hwrite_q   <= 1'b0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NRW; i++) reg_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      strb_q     <= strb_d;
      hwrite_q   <= hwrite_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NRW; i++) reg_q[i] <= reg_d[i];
    end
  end

  always_comb begin
    O_reg_q = '0;
    for (int i = 0; i < NRW; i++) O_reg_q[32*i +: 32] = reg_q[i];
  end

  assign O_wr_pulse       = wr_pulse_q;
  assign ahb.O_ahb_hready = hready;
  assign ahb.O_ahb_hresp  = (state_q == DP_ERR1 || state_q == DP_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign ahb.O_ahb_hrdata = (state_q == DP_DONE && !hwrite_q) ? rd_word : 32'h0;

endmodule
